// File: rtl/prog_mem_ctrl.sv
// Program memory controller: loads a program word-by-word, then fetches it
// sequentially with jump, stall and wrap-around support.
module prog_mem_ctrl #(
    parameter int unsigned           WORD_WIDTH = 32,
    parameter int unsigned           DEPTH      = 128,
    parameter int unsigned           ADDR_W     = 7,
    parameter logic [WORD_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rst_counter,
    input  logic                  ld_en,
    input  logic                  rd_en,
    input  logic [WORD_WIDTH-1:0] Load_data,
    input  logic                  jump,
    input  logic [ADDR_W-1:0]     jump_to,
    input  logic                  stall,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic [ADDR_W-1:0]     ins_addr,
    output logic                  ins_valid,
    output logic [ADDR_W:0]       prog_len,
    output logic                  full,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_e                  state_q;
    logic [WORD_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]       pc_q;
    logic [ADDR_W-1:0]       pc_d;
    logic [ADDR_W:0]         len_q;
    logic [WORD_WIDTH-1:0]   instr_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    valid_q;
    logic                    err_q;

    logic ld_only;
    logic rd_only;
    logic both_req;
    logic do_write;
    logic do_fetch;
    logic in_prog;
    logic jump_oob;

    // Mode decode; rst_counter outranks both requests, rst is handled in the flops.
    always_comb begin
        ld_only  = !rst_counter && ld_en && !rd_en;
        rd_only  = !rst_counter && rd_en && !ld_en;
        both_req = !rst_counter && ld_en && rd_en;
        do_write = !rst && ld_only && (state_q != RUN) && !full;
        do_fetch = rd_only && !stall;
        pc_d     = jump ? jump_to : pc_q + 1'b1;
        in_prog  = {1'b0, pc_q} < len_q;
        jump_oob = {1'b0, jump_to} >= len_q;
    end

    // Storage has no reset so it maps onto RAM and survives rst/rst_counter.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[len_q[ADDR_W-1:0]] <= Load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            instr_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (rst_counter) begin
            pc_q <= '0;
            if (state_q != RUN) begin
                len_q <= '0;
            end
        end else if (both_req) begin
            err_q <= 1'b1;
        end else if (ld_only) begin
            state_q <= LOAD;
            // Coming out of RUN spends one cycle turning around without writing.
            if (state_q != RUN) begin
                if (!full) begin
                    len_q <= len_q + 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end else if (rd_only) begin
            state_q <= RUN;
            if (do_fetch) begin
                addr_q <= pc_q;
                pc_q   <= pc_d;
                if (in_prog) begin
                    instr_q <= mem[pc_q];
                    valid_q <= 1'b1;
                end else begin
                    instr_q <= NOP_WORD;
                    valid_q <= 1'b0;
                end
                if (jump && jump_oob) begin
                    err_q <= 1'b1;
                end
            end
        end else begin
            state_q <= IDLE;
        end
    end

    assign full        = (len_q == DEPTH_L);
    assign prog_len    = len_q;
    assign instruction = instr_q;
    assign ins_addr    = addr_q;
    assign ins_valid   = valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Directed self-checking bench for prog_mem_ctrl with default parameters.
module tb_prog_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rst_counter, ld_en, rd_en, jump, stall;
    logic [31:0] Load_data;
    logic [6:0]  jump_to;
    logic [31:0] instruction;
    logic [6:0]  ins_addr;
    logic        ins_valid;
    logic [7:0]  prog_len;
    logic        full, err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] w [12] = '{32'h00A00929, 32'h005009A9, 32'h00B00A13, 32'h00C08193,
                            32'h40D10233, 32'h00E182B3, 32'h01F20313, 32'h00628393,
                            32'h0073A423, 32'h0084A483, 32'hFE551EE3, 32'h00F00929};
    logic [31:0] x [3]  = '{32'h11110001, 32'h22220002, 32'h33330003};

    prog_mem_ctrl #(.WORD_WIDTH(32), .DEPTH(128), .ADDR_W(7), .NOP_WORD(32'h0)) dut (
        .clk(clk), .rst(rst), .rst_counter(rst_counter), .ld_en(ld_en), .rd_en(rd_en),
        .Load_data(Load_data), .jump(jump), .jump_to(jump_to), .stall(stall),
        .instruction(instruction), .ins_addr(ins_addr), .ins_valid(ins_valid),
        .prog_len(prog_len), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [6:0] a, input logic [31:0] d,
                             input logic v);
        chk({tag, ".addr"},  64'(ins_addr),    64'(a));
        chk({tag, ".instr"}, 64'(instruction), 64'(d));
        chk({tag, ".valid"}, 64'(ins_valid),   64'(v));
    endtask

    initial begin
        rst = 1'b1; rst_counter = 1'b0; ld_en = 1'b0; rd_en = 1'b0;
        jump = 1'b0; stall = 1'b0; Load_data = '0; jump_to = '0;

        // Reset state
        step();
        rst = 1'b0;
        chk_fetch("reset", 7'd0, 32'h0, 1'b0);
        chk("reset.prog_len", 64'(prog_len), 64'd0);
        chk("reset.full", 64'(full), 64'd0);
        chk("reset.err", 64'(err), 64'd0);

        // Load 12 words
        ld_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            Load_data = w[i];
            step();
        end
        ld_en = 1'b0;
        chk("load12.prog_len", 64'(prog_len), 64'd12);
        chk("load12.full", 64'(full), 64'd0);
        chk("load12.err", 64'(err), 64'd0);

        // First fetch straight out of LOAD, then rewind PC while in RUN
        rd_en = 1'b1;
        step();
        chk_fetch("first", 7'd0, w[0], 1'b1);
        rst_counter = 1'b1;
        step();
        rst_counter = 1'b0;
        chk("rstcnt_run.prog_len", 64'(prog_len), 64'd12);
        chk("rstcnt_run.addr_held", 64'(ins_addr), 64'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk_fetch($sformatf("seq%0d", i), 7'(i), w[i], 1'b1);
        end

        // Stall mid-run, with a jump that must be ignored
        rst_counter = 1'b1;
        step();
        rst_counter = 1'b0;
        step(); step(); step();
        chk_fetch("prestall", 7'd2, w[2], 1'b1);
        stall = 1'b1; jump = 1'b1; jump_to = 7'd9;
        step();
        jump = 1'b0;
        chk_fetch("stall0", 7'd2, w[2], 1'b1);
        step();
        chk_fetch("stall1", 7'd2, w[2], 1'b1);
        step();
        chk_fetch("stall2", 7'd2, w[2], 1'b1);
        stall = 1'b0;
        step();
        chk_fetch("resume", 7'd3, w[3], 1'b1);

        // Jumps: in range at PC 10, then out of range
        rst_counter = 1'b1;
        step();
        rst_counter = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk_fetch("pre_jump", 7'd9, w[9], 1'b1);
        jump = 1'b1; jump_to = 7'd6;
        step();
        jump = 1'b0;
        chk_fetch("jump_src", 7'd10, w[10], 1'b1);
        step();
        chk_fetch("jump_dst", 7'd6, w[6], 1'b1);
        chk("jump_in.err", 64'(err), 64'd0);
        jump = 1'b1; jump_to = 7'd20;
        step();
        jump = 1'b0;
        chk_fetch("jump_oob_src", 7'd7, w[7], 1'b1);
        chk("jump_oob.err", 64'(err), 64'd1);
        step();
        chk_fetch("jump_oob_dst", 7'd20, 32'h0, 1'b0);

        // Fresh 3-word program: illegal request, run past end, wrap
        rd_en = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2.err", 64'(err), 64'd0);
        ld_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Load_data = x[i];
            step();
        end
        Load_data = 32'hDEADBEEF; rd_en = 1'b1;
        step();
        chk("illegal.prog_len", 64'(prog_len), 64'd3);
        chk("illegal.err", 64'(err), 64'd1);
        chk("illegal.addr", 64'(ins_addr), 64'd0);
        ld_en = 1'b0;
        step();
        chk_fetch("p3_0", 7'd0, x[0], 1'b1);
        step();
        chk_fetch("p3_1", 7'd1, x[1], 1'b1);
        step();
        chk_fetch("p3_2", 7'd2, x[2], 1'b1);
        step();
        chk_fetch("p3_end", 7'd3, 32'h0, 1'b0);
        for (int a = 4; a <= 127; a++) step();
        chk_fetch("p3_last", 7'd127, 32'h0, 1'b0);
        step();
        chk_fetch("p3_wrap", 7'd0, x[0], 1'b1);

        // Overfill: 129 words into a 128-deep memory
        rd_en = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; ld_en = 1'b1;
        for (int i = 0; i < 128; i++) begin
            Load_data = 32'hC000_0000 | 32'(i);
            step();
        end
        chk("fill128.prog_len", 64'(prog_len), 64'd128);
        chk("fill128.full", 64'(full), 64'd1);
        chk("fill128.err", 64'(err), 64'd0);
        Load_data = 32'hD0D0D0D0;
        step();
        chk("over.prog_len", 64'(prog_len), 64'd128);
        chk("over.err", 64'(err), 64'd1);
        ld_en = 1'b0; rd_en = 1'b1; jump = 1'b1; jump_to = 7'd127;
        step();
        jump = 1'b0;
        chk_fetch("full_0", 7'd0, 32'hC0000000, 1'b1);
        step();
        chk_fetch("full_127", 7'd127, 32'hC000007F, 1'b1);
        step();
        chk_fetch("full_wrap", 7'd0, 32'hC0000000, 1'b1);

        // rst_counter outside RUN clears the load pointer, then rst mid-load
        rd_en = 1'b0;
        step();
        rst_counter = 1'b1;
        step();
        rst_counter = 1'b0;
        chk("rstcnt_idle.prog_len", 64'(prog_len), 64'd0);
        chk("rstcnt_idle.full", 64'(full), 64'd0);
        ld_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Load_data = 32'hA5A50000 | 32'(i);
            step();
        end
        chk("load5.prog_len", 64'(prog_len), 64'd5);
        chk_fetch("load5.held", 7'd0, 32'hC0000000, 1'b1);
        Load_data = 32'hA5A50005; rst = 1'b1;
        step();
        rst = 1'b0;
        chk_fetch("rst_mid", 7'd0, 32'h0, 1'b0);
        chk("rst_mid.prog_len", 64'(prog_len), 64'd0);
        chk("rst_mid.err", 64'(err), 64'd0);
        chk("rst_mid.full", 64'(full), 64'd0);
        Load_data = 32'h7E57C0DE;
        step();
        ld_en = 1'b0; rd_en = 1'b1;
        step();
        chk_fetch("reload_0", 7'd0, 32'h7E57C0DE, 1'b1);
        chk("reload.prog_len", 64'(prog_len), 64'd1);
        step();
        chk_fetch("reload_1", 7'd1, 32'h0, 1'b0);
        rd_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_mem_ctrl.md
PROG_MEM_CTRL -- requirements
Module: prog_mem_ctrl

Interface
REQ-001 Parameter WORD_WIDTH, default 32: instruction/data word width in bits.
REQ-002 Parameter DEPTH, default 128: number of program words stored.
REQ-003 Parameter ADDR_W, default 7: address width; SHALL satisfy 2**ADDR_W == DEPTH.
REQ-004 Parameter NOP_WORD, default 0: word emitted on a fetch outside the loaded program.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rst_counter  input  1  synchronous clear of fetch PC and (outside RUN) load pointer.
REQ-008 ld_en  input  1  load-mode request; writes Load_data at load pointer.
REQ-009 rd_en  input  1  run-mode request; fetches one word per unstalled cycle.
REQ-010 Load_data  input  WORD_WIDTH  program word to store.
REQ-011 jump  input  1  redirect next fetch to jump_to.
REQ-012 jump_to  input  ADDR_W  jump target address.
REQ-013 stall  input  1  freeze fetch outputs and PC.
REQ-014 instruction  output  WORD_WIDTH  registered fetched word.
REQ-015 ins_addr  output  ADDR_W  address of word on instruction.
REQ-016 ins_valid  output  1  instruction holds a word from the loaded program.
REQ-017 prog_len  output  ADDR_W+1  number of words loaded (0..DEPTH).
REQ-018 full  output  1  prog_len == DEPTH.
REQ-019 err  output  1  sticky error flag.

Function
REQ-020 State machine SHALL have states IDLE, LOAD, RUN; encoding is implementation choice.
REQ-021 Mode decode each cycle, priority order: rst; rst_counter; ld_en&rd_en (illegal); ld_en; rd_en; neither.
REQ-022 rst_counter: PC <= 0; if state != RUN, load pointer and prog_len <= 0; no write/fetch that cycle; state unchanged.
REQ-023 ld_en&rd_en both high: no write, no fetch, err <= 1, state unchanged.
REQ-024 ld_en only, state IDLE or LOAD: state <= LOAD; if !full, mem[prog_len] <= Load_data and prog_len increments by 1; if full, write dropped and err <= 1.
REQ-025 ld_en only, state RUN: state <= LOAD, no write this cycle (one-cycle mode turnaround).
REQ-026 rd_en only: state <= RUN; fetch SHALL occur in the same cycle, including the first cycle after LOAD/IDLE.
REQ-027 Fetch (rd_en, !stall): ins_addr <= PC; if PC < prog_len, instruction <= mem[PC], ins_valid <= 1; else instruction <= NOP_WORD, ins_valid <= 0.
REQ-028 Fetch latency: word at address A appears on instruction one clock after the edge where PC == A is sampled.
REQ-029 Next PC: jump ? jump_to : PC+1, modulo DEPTH (PC DEPTH-1 wraps to 0).
REQ-030 jump with jump_to >= prog_len: jump still taken, err <= 1.
REQ-031 jump sampled only on an unstalled fetch cycle; ignored otherwise.
REQ-032 stall high with rd_en: PC, instruction, ins_addr, ins_valid held.
REQ-033 Neither ld_en nor rd_en: state <= IDLE; PC, prog_len, fetch outputs held.
REQ-034 full SHALL be combinational from prog_len; all other outputs registered.
REQ-035 Memory contents SHALL persist across modes and rst_counter; reads never return partially written data.

Reset
REQ-036 On rst: state IDLE, PC 0, prog_len 0, instruction 0, ins_addr 0, ins_valid 0, err 0, full 0.
REQ-037 rst SHALL NOT clear memory array; contents after rst are unspecified until reloaded.
REQ-038 rst mid-load or mid-run SHALL abort the operation with no write that cycle.
REQ-039 err SHALL be cleared only by rst.

Verification
REQ-040 Load 12 words (00A00929, 005009A9, ..., 00F00929), pulse rst_counter, rd_en -> instruction sequence equals loaded words, ins_addr 0..11, ins_valid 1, prog_len 12.
REQ-041 Run past end of 3-word program -> addr 3 gives NOP_WORD with ins_valid 0; after addr 127, PC wraps to 0 and mem[0] returns with ins_valid 1.
REQ-042 During run, jump=1 jump_to=6 at PC 10 -> next ins_addr 6; jump_to=20 with prog_len 12 -> ins_addr 20, ins_valid 0, err 1.
REQ-043 Load 129 words into DEPTH=128 -> prog_len 128, full 1, word 129 dropped, err 1; mem[127] intact.
REQ-044 ld_en and rd_en high together for one cycle -> no change to prog_len/PC, err 1; stall 3 cycles mid-run -> outputs frozen, sequence resumes without skip.
REQ-045 rst asserted mid-load after 5 words -> all outputs 0 next cycle, state IDLE, subsequent load starts at address 0.
